// File: rtl/blake2_pkg.sv
// Shared BLAKE2 message schedule (SIGMA), G step word indices and scheduler state type.
package blake2_pkg;

  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

  // Row r holds SIGMA[r][0..15] as nibbles, entry j at bits [4*j +: 4].
  localparam logic [63:0] SIGMA [10] = '{
    64'hFEDC_BA98_7654_3210,
    64'h357B_20C1_6DF9_84AE,
    64'h4917_63EA_DF25_0C8B,
    64'h8F04_A562_EBCD_1397,
    64'hD386_CB1E_FA42_7509,
    64'h91EF_57D4_38B0_A6C2,
    64'hB829_3670_A4DE_F15C,
    64'h2A68_4F05_931C_E7BD,
    64'h5A41_7D2C_803B_9EF6,
    64'h0DC3_E9BF_5167_482A
  };

  // Step s packs {d, c, b, a} word indices, one nibble each.
  localparam logic [15:0] STEP_IDX [8] = '{
    16'hC840, 16'hD951, 16'hEA62, 16'hFB73,
    16'hFA50, 16'hCB61, 16'hD872, 16'hE943
  };

endpackage

// File: rtl/blake2_sigma.sv
// SIGMA lookup: message word indices for the two G inputs of (round, step).
module blake2_sigma
  import blake2_pkg::*;
(
  input  logic [3:0] round,
  input  logic [2:0] step,
  output logic [3:0] x_idx,
  output logic [3:0] y_idx
);

  logic [3:0]  rmod;
  logic [63:0] row;

  always_comb begin
    rmod  = (round >= 4'd10) ? round - 4'd10 : round;
    row   = SIGMA[rmod];
    x_idx = row[{step, 1'b0, 2'b00} +: 4];
    y_idx = row[{step, 1'b1, 2'b00} +: 4];
  end

endmodule

// File: rtl/blake2_round_sched.sv
// BLAKE2 round scheduler: one external G step per cycle over a registered working vector.
// Optional abort_i port enabled by defining BLAKE2_ROUND_SCHED_ABORT_EN.
module blake2_round_sched
  import blake2_pkg::*;
#(
  parameter int W      = 32,
  parameter int ROUNDS = 10
) (
  input  logic            clk,
  input  logic            nreset,
`ifdef BLAKE2_ROUND_SCHED_ABORT_EN
  input  logic            abort_i,
`endif
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [16*W-1:0] v_i,
  input  logic [16*W-1:0] m_i,
  output logic [W-1:0]    g_a_o,
  output logic [W-1:0]    g_b_o,
  output logic [W-1:0]    g_c_o,
  output logic [W-1:0]    g_d_o,
  output logic [W-1:0]    g_x_o,
  output logic [W-1:0]    g_y_o,
  input  logic [W-1:0]    g_a_i,
  input  logic [W-1:0]    g_b_i,
  input  logic [W-1:0]    g_c_i,
  input  logic [W-1:0]    g_d_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [16*W-1:0] v_o
);

  state_t       state, state_nxt;
  logic [3:0]   round;
  logic [2:0]   step;
  logic [W-1:0] v_q [16];
  logic [W-1:0] m_q [16];
  logic [3:0]   a_idx, b_idx, c_idx, d_idx, x_idx, y_idx;
  logic         accept, last_step, abort;

`ifdef BLAKE2_ROUND_SCHED_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign accept    = (state == IDLE) && valid_i;
  assign last_step = (step == 3'd7) && (round == 4'(ROUNDS - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (valid_i) state_nxt = MIX;
      MIX:     if (abort) state_nxt = IDLE;
               else if (last_step) state_nxt = DONE;
      DONE:    if (abort || ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE);
    valid_o = (state == DONE);
  end

  always_comb begin
    {d_idx, c_idx, b_idx, a_idx} = STEP_IDX[step];
  end

  blake2_sigma u_sigma (
    .round (round),
    .step  (step),
    .x_idx (x_idx),
    .y_idx (y_idx)
  );

  assign g_a_o = v_q[a_idx];
  assign g_b_o = v_q[b_idx];
  assign g_c_o = v_q[c_idx];
  assign g_d_o = v_q[d_idx];
  assign g_x_o = m_q[x_idx];
  assign g_y_o = m_q[y_idx];

  // An aborting edge clears the counters but skips the write-back of that step.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      round <= '0;
      step  <= '0;
      for (int unsigned k = 0; k < 16; k++) begin
        v_q[k] <= '0;
        m_q[k] <= '0;
      end
    end else if (accept) begin
      round <= '0;
      step  <= '0;
      for (int unsigned k = 0; k < 16; k++) begin
        v_q[k] <= v_i[k*W +: W];
        m_q[k] <= m_i[k*W +: W];
      end
    end else if (state == MIX) begin
      if (abort) begin
        round <= '0;
        step  <= '0;
      end else begin
        v_q[a_idx] <= g_a_i;
        v_q[b_idx] <= g_b_i;
        v_q[c_idx] <= g_c_i;
        v_q[d_idx] <= g_d_i;
        step       <= step + 3'd1;
        if (step == 3'd7) round <= last_step ? '0 : round + 4'd1;
      end
    end
  end

  always_comb begin
    v_o = '0;
    for (int unsigned k = 0; k < 16; k++) v_o[k*W +: W] = v_q[k];
  end

endmodule

// File: tb/tb_blake2_round_sched.sv
// Bench for blake2_round_sched: W=32/ROUNDS=10 and W=64/ROUNDS=12 instances, G wired in.
module tb_blake2_round_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks, failures;
  int sel;
  logic g_mode;  // 1: G passes operands straight back, so v never changes
  logic nreset, req_valid, req_ready, req_abort;
  logic [1023:0] req_v, req_m;

  int sig [10][16] = '{
    '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
    '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
    '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
    '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
    '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
    '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
    '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
    '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6,10, 2},
    '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}
  };
  int mix_idx [8][4] = '{
    '{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
    '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}
  };

  function automatic logic [63:0] rotr(logic [63:0] x, int n, int w);
    logic [63:0] mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    x = x & mask;
    return ((x >> n) | (x << (w - n))) & mask;
  endfunction

  function automatic logic [255:0] g_fn(int w, logic [63:0] a0, b0, c0, d0, x, y);
    logic [63:0] mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    logic [63:0] a, b, c, d;
    a = (a0 + b0 + x) & mask;
    d = rotr(d0 ^ a, (w == 32) ? 16 : 32, w);
    c = (c0 + d) & mask;
    b = rotr(b0 ^ c, (w == 32) ? 12 : 24, w);
    a = (a + b + y) & mask;
    d = rotr(d ^ a, (w == 32) ? 8 : 16, w);
    c = (c + d) & mask;
    b = rotr(b ^ c, (w == 32) ? 7 : 63, w);
    return {a, b, c, d};
  endfunction

  // Reference: the first nsteps G applications of a BLAKE2 compression (64-bit slots).
  function automatic logic [1023:0] compress(logic [1023:0] vin, mblk, int w, int rounds, int nsteps);
    logic [63:0]   v [16];
    logic [63:0]   m [16];
    logic [255:0]  r;
    logic [1023:0] res;
    int t = 0;
    for (int k = 0; k < 16; k++) begin
      v[k] = vin[k*64 +: 64];
      m[k] = mblk[k*64 +: 64];
    end
    for (int rr = 0; rr < rounds; rr++) begin
      for (int j = 0; j < 8; j++) begin
        if (t < nsteps) begin
          r = g_fn(w, v[mix_idx[j][0]], v[mix_idx[j][1]], v[mix_idx[j][2]], v[mix_idx[j][3]],
                   m[sig[rr % 10][2*j]], m[sig[rr % 10][2*j+1]]);
          v[mix_idx[j][0]] = r[255:192];
          v[mix_idx[j][1]] = r[191:128];
          v[mix_idx[j][2]] = r[127:64];
          v[mix_idx[j][3]] = r[63:0];
        end
        t++;
      end
    end
    for (int k = 0; k < 16; k++) res[k*64 +: 64] = v[k];
    return res;
  endfunction

  // DUT-side signals
  logic valid32, ready32, vld_o32, rdy_i32, abort32;
  logic valid64, ready64, vld_o64, rdy_i64, abort64;
  logic [511:0]  v_i32, m_i32, v_o32;
  logic [1023:0] v_i64, m_i64, v_o64;
  logic [31:0] ga_o32, gb_o32, gc_o32, gd_o32, gx_o32, gy_o32, ga_i32, gb_i32, gc_i32, gd_i32;
  logic [63:0] ga_o64, gb_o64, gc_o64, gd_o64, gx_o64, gy_o64, ga_i64, gb_i64, gc_i64, gd_i64;
  logic [255:0] r32, r64;

  assign valid32 = req_valid && (sel == 0);
  assign valid64 = req_valid && (sel == 1);
  assign rdy_i32 = req_ready && (sel == 0);
  assign rdy_i64 = req_ready && (sel == 1);
  assign abort32 = req_abort && (sel == 0);
  assign abort64 = req_abort && (sel == 1);
  assign v_i64   = req_v;
  assign m_i64   = req_m;

  always_comb begin
    v_i32 = '0;
    m_i32 = '0;
    for (int k = 0; k < 16; k++) begin
      v_i32[k*32 +: 32] = req_v[k*64 +: 32];
      m_i32[k*32 +: 32] = req_m[k*64 +: 32];
    end
  end

  always_comb begin
    r32 = g_fn(32, 64'(ga_o32), 64'(gb_o32), 64'(gc_o32), 64'(gd_o32), 64'(gx_o32), 64'(gy_o32));
    r64 = g_fn(64, ga_o64, gb_o64, gc_o64, gd_o64, gx_o64, gy_o64);
    if (g_mode) begin
      {ga_i32, gb_i32, gc_i32, gd_i32} = {ga_o32, gb_o32, gc_o32, gd_o32};
      {ga_i64, gb_i64, gc_i64, gd_i64} = {ga_o64, gb_o64, gc_o64, gd_o64};
    end else begin
      {ga_i32, gb_i32, gc_i32, gd_i32} = {r32[223:192], r32[159:128], r32[95:64], r32[31:0]};
      {ga_i64, gb_i64, gc_i64, gd_i64} = r64;
    end
  end

  // Views of the selected instance, words in 64-bit slots
  logic cur_valid, cur_ready;
  logic [1023:0] cur_vo;
  logic [63:0] cur_ga, cur_gb, cur_gc, cur_gd, cur_gx, cur_gy;
  always_comb begin
    cur_valid = (sel == 1) ? vld_o64 : vld_o32;
    cur_ready = (sel == 1) ? ready64 : ready32;
    cur_ga = (sel == 1) ? ga_o64 : 64'(ga_o32);
    cur_gb = (sel == 1) ? gb_o64 : 64'(gb_o32);
    cur_gc = (sel == 1) ? gc_o64 : 64'(gc_o32);
    cur_gd = (sel == 1) ? gd_o64 : 64'(gd_o32);
    cur_gx = (sel == 1) ? gx_o64 : 64'(gx_o32);
    cur_gy = (sel == 1) ? gy_o64 : 64'(gy_o32);
    cur_vo = '0;
    for (int k = 0; k < 16; k++)
      cur_vo[k*64 +: 64] = (sel == 1) ? v_o64[k*64 +: 64] : 64'(v_o32[k*32 +: 32]);
  end

  blake2_round_sched #(.W(32), .ROUNDS(10)) u_dut32 (
    .clk(clk), .nreset(nreset),
`ifdef BLAKE2_ROUND_SCHED_ABORT_EN
    .abort_i(abort32),
`endif
    .valid_i(valid32), .ready_o(ready32), .v_i(v_i32), .m_i(m_i32),
    .g_a_o(ga_o32), .g_b_o(gb_o32), .g_c_o(gc_o32), .g_d_o(gd_o32), .g_x_o(gx_o32), .g_y_o(gy_o32),
    .g_a_i(ga_i32), .g_b_i(gb_i32), .g_c_i(gc_i32), .g_d_i(gd_i32),
    .valid_o(vld_o32), .ready_i(rdy_i32), .v_o(v_o32)
  );

  blake2_round_sched #(.W(64), .ROUNDS(12)) u_dut64 (
    .clk(clk), .nreset(nreset),
`ifdef BLAKE2_ROUND_SCHED_ABORT_EN
    .abort_i(abort64),
`endif
    .valid_i(valid64), .ready_o(ready64), .v_i(v_i64), .m_i(m_i64),
    .g_a_o(ga_o64), .g_b_o(gb_o64), .g_c_o(gc_o64), .g_d_o(gd_o64), .g_x_o(gx_o64), .g_y_o(gy_o64),
    .g_a_i(ga_i64), .g_b_i(gb_i64), .g_c_i(gc_i64), .g_d_i(gd_i64),
    .valid_o(vld_o64), .ready_i(rdy_i64), .v_o(v_o64)
  );

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_vec(string nm, logic [1023:0] act, logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int k = 0; k < 16; k++)
        if (act[k*64 +: 64] !== exp[k*64 +: 64]) begin
          $display("FAIL %s word %0d: got %h expected %h", nm, k, act[k*64 +: 64], exp[k*64 +: 64]);
          break;
        end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] rand_vec(int w);
    logic [1023:0] r;
    logic [63:0] x;
    for (int k = 0; k < 16; k++) begin
      x = {$urandom, $urandom};
      if (w == 32) x[63:32] = '0;
      r[k*64 +: 64] = x;
    end
    return r;
  endfunction

  function automatic int cur_w();
    return (sel == 1) ? 64 : 32;
  endfunction

  function automatic int cur_rounds();
    return (sel == 1) ? 12 : 10;
  endfunction

  task automatic start_job(logic [1023:0] v, logic [1023:0] m);
    check("ready_o before accept", 64'(cur_ready), 64'd1);
    req_v = v;
    req_m = m;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(int exp_lat);
    int lat = 0;
    while (!cur_valid && lat < 400) begin
      tick();
      lat++;
    end
    check("done latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic release_job();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("idle after release", {62'd0, cur_ready, cur_valid}, 64'd2);
  endtask

  task automatic run_job(logic [1023:0] v, logic [1023:0] m);
    logic [1023:0] exp = compress(v, m, cur_w(), cur_rounds(), 8 * cur_rounds());
    start_job(v, m);
    wait_done(8 * cur_rounds());
    check_vec("v_o result", cur_vo, exp);
    release_job();
    repeat (3) tick();
    check_vec("v_o held in idle", cur_vo, exp);
  endtask

  typedef struct {
    int sel, rnd, stp;
    int a, b, c, d, x, y;
  } vec_t;
  vec_t tbl [10];

  initial begin
    logic [1023:0] vpt, mcnt, v, m, exp;
    int k0;
    bit saw;

    tbl[0] = '{0, 0,0, 0,4,8,12,  0,1};
    tbl[1] = '{0, 1,0, 0,4,8,12, 14,10};
    tbl[2] = '{1,10,0, 0,4,8,12,  0,1};
    tbl[3] = '{0, 0,5, 1,6,11,12, 10,11};
    tbl[4] = '{0, 1,7, 3,4,9,14,  5,3};
    tbl[5] = '{0, 9,3, 3,7,11,15, 1,5};
    tbl[6] = '{1,11,6, 2,7,8,13, 11,7};
    tbl[7] = '{1, 4,4, 0,5,10,15, 14,1};
    tbl[8] = '{0, 2,2, 2,6,10,14, 5,2};
    tbl[9] = '{1, 7,1, 1,5,9,13,  7,14};

    checks = 0; failures = 0; sel = 0; g_mode = 1'b0;
    req_valid = 1'b0; req_ready = 1'b0; req_abort = 1'b0;
    req_v = '0; req_m = '0;
    nreset = 1'b0;

    #3;
    for (int i = 0; i < 2; i++) begin
      sel = i;
      #1;
      check("reset ready/valid", {62'd0, cur_ready, cur_valid}, 64'd2);
      check_vec("reset v_o", cur_vo, '0);
    end
    sel = 0;
    nreset = 1'b1;
    tick();

    // All-zero job stays zero and finishes after 80 edges
    run_job('0, '0);
    check_vec("zero job v_o", cur_vo, '0);

    // Operand selection per (round, step) with a pass-through G
    g_mode = 1'b1;
    for (int k = 0; k < 16; k++) begin
      vpt[k*64 +: 64]  = 64'(1000 + k);
      mcnt[k*64 +: 64] = 64'(k);
    end
    for (int i = 0; i < 10; i++) begin
      sel = tbl[i].sel;
      k0 = 8 * tbl[i].rnd + tbl[i].stp;
      start_job(vpt, mcnt);
      repeat (k0) tick();
      check("g abcd operands", {cur_ga[15:0], cur_gb[15:0], cur_gc[15:0], cur_gd[15:0]},
            {16'(1000 + tbl[i].a), 16'(1000 + tbl[i].b), 16'(1000 + tbl[i].c), 16'(1000 + tbl[i].d)});
      check("g xy operands", {cur_gx[31:0], cur_gy[31:0]}, {32'(tbl[i].x), 32'(tbl[i].y)});
      wait_done(8 * cur_rounds() - k0);
      check_vec("pass-through v_o", cur_vo, vpt);
      release_job();
    end
    g_mode = 1'b0;

    // Random jobs against the reference compression
    for (int s = 0; s < 2; s++) begin
      sel = s;
      repeat (3) run_job(rand_vec(cur_w()), rand_vec(cur_w()));
    end

    // DONE holds while ready_i is low; valid_i pulses are ignored
    sel = 0;
    v = rand_vec(32);
    m = rand_vec(32);
    exp = compress(v, m, 32, 10, 80);
    start_job(v, m);
    wait_done(80);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2 == 0);
      req_v = rand_vec(32);
      tick();
      check("done hold ready/valid", {62'd0, cur_ready, cur_valid}, 64'd1);
      check_vec("done hold v_o", cur_vo, exp);
    end
    req_valid = 1'b0;
    release_job();
    tick();
    check("no queued job", 64'(cur_ready), 64'd1);
    check_vec("v_o after hold", cur_vo, exp);

    // Reset mid-MIX abandons the job
    v = rand_vec(32);
    m = rand_vec(32);
    start_job(v, m);
    repeat (40) tick();
    nreset = 1'b0;
    #1;
    check("mid-mix reset ready/valid", {62'd0, cur_ready, cur_valid}, 64'd2);
    check_vec("mid-mix reset v_o", cur_vo, '0);
    #2 nreset = 1'b1;
    saw = 1'b0;
    repeat (100) begin
      tick();
      saw |= cur_valid;
    end
    check("no valid after reset", 64'(saw), 64'd0);
    run_job(rand_vec(32), rand_vec(32));

`ifdef BLAKE2_ROUND_SCHED_ABORT_EN
    // Abort at MIX cycle 10 keeps v as it stood and never raises valid_o
    for (int s = 0; s < 2; s++) begin
      sel = s;
      v = rand_vec(cur_w());
      m = rand_vec(cur_w());
      exp = compress(v, m, cur_w(), cur_rounds(), 10);
      start_job(v, m);
      repeat (10) tick();
      req_abort = 1'b1;
      tick();
      req_abort = 1'b0;
      check("abort ready/valid", {62'd0, cur_ready, cur_valid}, 64'd2);
      check_vec("abort v_o", cur_vo, exp);
      saw = 1'b0;
      repeat (110) begin
        tick();
        saw |= cur_valid;
      end
      check("no valid after abort", 64'(saw), 64'd0);
      run_job(rand_vec(cur_w()), rand_vec(cur_w()));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blake2_round_sched.md
BLAKE2_ROUND_SCHED -- requirements
Module: blake2_round_sched

Interface
REQ-001 SHALL have parameter W, default 32, word width (32 = BLAKE2s, 64 = BLAKE2b).
REQ-002 SHALL have parameter ROUNDS, default 10, rounds per compression (10 for W=32, 12 for W=64).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port nreset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port valid_i  input  1  v_i/m_i valid.
REQ-006 SHALL have port ready_o  output  1  block can accept a new job.
REQ-007 SHALL have port v_i  input  16*W  initial working vector, word k at [k*W +: W].
REQ-008 SHALL have port m_i  input  16*W  message block, word k at [k*W +: W].
REQ-009 SHALL have ports g_a_o, g_b_o, g_c_o, g_d_o, g_x_o, g_y_o  output  W each  operands to the external combinational G.
REQ-010 SHALL have ports g_a_i, g_b_i, g_c_i, g_d_i  input  W each  G results.
REQ-011 SHALL have port valid_o  output  1  v_o holds the final working vector.
REQ-012 SHALL have port ready_i  input  1  downstream accepts v_o.
REQ-013 SHALL have port v_o  output  16*W  registered working vector.

Function
REQ-014 SHALL implement FSM IDLE, MIX and DONE; ready_o = (state==IDLE); valid_o = (state==DONE).
REQ-015 SHALL, in IDLE on valid_i&&ready_o, register v_i and m_i, clear round and step counters, and enter MIX.
REQ-016 SHALL, in MIX, perform one G step per cycle, step 0..7 within round 0..ROUNDS-1.
REQ-017 SHALL select (a,b,c,d) per step: 0:(0,4,8,12) 1:(1,5,9,13) 2:(2,6,10,14) 3:(3,7,11,15) 4:(0,5,10,15) 5:(1,6,11,12) 6:(2,7,8,13) 7:(3,4,9,14).
REQ-018 SHALL drive g_x_o = m[SIGMA[round mod 10][2*step]] and g_y_o = m[SIGMA[round mod 10][2*step+1]].
REQ-019 SHALL write g_a_i..g_d_i back into v[a],v[b],v[c],v[d] on the same edge; the other 12 words are unchanged.
REQ-020 SHALL increment step each MIX cycle; on step 7 wrap step to 0 and increment round; on step 7 of round ROUNDS-1 enter DONE.
REQ-021 SHALL assert valid_o exactly 8*ROUNDS clock edges after the accept edge (80 for W=32, 96 for W=64).
REQ-022 SHALL hold v_o and valid_o stable in DONE while ready_i=0; on valid_i... no: on ready_i=1 return to IDLE on that edge.
REQ-023 SHALL ignore valid_i outside IDLE; no job is queued.
REQ-024 SHALL drive g_*_o from state only (no combinational path from valid_i or ready_i).
REQ-025 SHALL tolerate arbitrary G outputs in IDLE/DONE; no write-back occurs outside MIX.

Reset
REQ-026 SHALL on nreset low asynchronously force state=IDLE, round=0, step=0, v and m registers to 0; hence ready_o=1, valid_o=0, v_o=0.
REQ-027 SHALL abandon any in-flight job on reset mid-MIX or mid-DONE; no valid_o follows release.

Configuration
REQ-028 SHALL, with BLAKE2_ROUND_SCHED_ABORT_EN defined, add port abort_i (input, 1): when high at an edge in MIX or DONE, state goes to IDLE, counters clear, v unchanged, valid_o not asserted for that job; abort_i takes priority over the final-step transition.
REQ-029 SHALL, without BLAKE2_ROUND_SCHED_ABORT_EN, have no abort_i port; the job always runs to DONE.

Structure
REQ-030 SHALL place the 10x16 SIGMA table, the 8x4 step index table and the FSM state enum in shared package blake2_pkg.
REQ-031 SHALL isolate the SIGMA/round-mod-10 lookup in sub-module blake2_sigma (inputs round, step; outputs x index, y index, 4 bits each).

Verification
REQ-032 SHALL check: v_i=0, m_i=0, W=32 -> valid_o after exactly 80 edges, v_o=0.
REQ-033 SHALL check: m_i word k = k -> (g_x_o,g_y_o) = (0,1) at round 0 step 0, (14,10) at round 1 step 0, and (0,1) at round 10 step 0 for W=64,ROUNDS=12.
REQ-034 SHALL check: random v_i/m_i vs a software BLAKE2 round model with the G function wired in -> v_o bit-exact for W=32 and W=64.
REQ-035 SHALL check: ready_i low 5 cycles in DONE -> v_o/valid_o stable, ready_o=0, valid_i pulses ignored; ready_i high -> IDLE next edge.
REQ-036 SHALL check: nreset pulse at MIX cycle 40 -> immediate ready_o=1, valid_o=0, v_o=0; a new job then completes in 80 cycles.
REQ-037 SHALL check (ABORT_EN): abort_i at MIX cycle 10 -> IDLE next edge, no valid_o; a following job is correct.
